// File: rtl/unpack_rq0_if.sv
// unpack_rq0_if
//   Groups the packed-byte input stream and the coefficient output stream
//   of the Rq0 unpacker.
//   Byte stream:        in_data[7:0], in_valid, in_ready
//   Coefficient stream: coef_data[LOGQ-1:0], coef_valid, coef_ready, coef_last
//   Status:             frame_done (one-cycle pulse), pad_err (sticky per frame)
//   Modports: master = the side feeding bytes and consuming coefficients,
//             slave  = the unpacker itself.
interface unpack_rq0_if #(
    parameter int LOGQ = 13
);
    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_ready;
    logic [LOGQ-1:0] coef_data;
    logic            coef_valid;
    logic            coef_ready;
    logic            coef_last;
    logic            frame_done;
    logic            pad_err;

    modport master (
        output in_data, in_valid, coef_ready,
        input  in_ready, coef_data, coef_valid, coef_last, frame_done, pad_err
    );

    modport slave (
        input  in_data, in_valid, coef_ready,
        output in_ready, coef_data, coef_valid, coef_last, frame_done, pad_err
    );
endinterface

// File: rtl/unpack_rq0.sv
// unpack_rq0
//   Streaming unpacker for packed Rq0 polynomials (NTRU-HRSS, N=701, q=8192).
//   Accepts 1138 packed bytes (MSB of each byte first in the bit stream),
//   emits 700 LSB-first 13-bit coefficients, then appends coefficient 700
//   as the negated sum of the others mod 8192.
//   Ports:
//     clk    - clock, rising edge
//     rst_n  - synchronous active-low reset
//     bus    - unpack_rq0_if.slave (byte stream in, coefficient stream out,
//              frame_done pulse, pad_err flag)
//   Build option: define UNPACK_RQ0_PAD_CHECK_EN to check that the 4 padding
//   bits at the end of the last byte are zero; otherwise pad_err is tied low.
//   Every output is a flop whose next value is derived from the next state,
//   so nothing combinational reaches an output from in_valid or coef_ready.
module unpack_rq0 #(
    parameter int N    = 701,
    parameter int LOGQ = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    unpack_rq0_if.slave  bus
);

    localparam int             ACC_W    = LOGQ + 7;
    localparam int             NB_INT   = ((N - 1) * LOGQ + 7) / 8;
    localparam int             PAD_W    = NB_INT * 8 - (N - 1) * LOGQ;
    localparam logic [10:0]    NBYTES   = 11'(NB_INT);
    localparam logic [9:0]     LAST_IDX = 10'(N - 2);
    localparam logic [4:0]     CNT_Q    = 5'(LOGQ);

    typedef enum logic [1:0] {RUN, CHECK, LAST, DONE} state_t;

    // Byte bit 7 is the earliest stream bit, so it lands at the lowest
    // free accumulator position.
    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7 - i];
        return r;
    endfunction

    function automatic logic [LOGQ-1:0] neg_mod(input logic [LOGQ-1:0] v);
        return '0 - v;
    endfunction

    state_t          state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [4:0]      cnt, cnt_nxt;
    logic [10:0]     bcnt, bcnt_nxt;
    logic [9:0]      ccnt, ccnt_nxt;
    logic [LOGQ-1:0] sum, sum_nxt;

    logic            in_ready_r, in_ready_nxt;
    logic            coef_valid_r, coef_valid_nxt;
    logic            coef_last_r, coef_last_nxt;
    logic            frame_done_r, frame_done_nxt;
    logic [LOGQ-1:0] coef_data_r, coef_data_nxt;

    logic            byte_fire;
    logic            coef_fire;

    assign byte_fire = bus.in_valid && in_ready_r;
    assign coef_fire = coef_valid_r && bus.coef_ready;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        bcnt_nxt  = bcnt;
        ccnt_nxt  = ccnt;
        sum_nxt   = sum;
        case (state)
            RUN: begin
                // in_ready and coef_valid are mutually exclusive (cnt<13 vs
                // cnt>=13), so at most one of these fires per cycle.
                if (byte_fire) begin
                    acc_nxt  = acc | (ACC_W'(bit_rev8(bus.in_data)) << cnt);
                    cnt_nxt  = cnt + 5'd8;
                    bcnt_nxt = bcnt + 11'd1;
                end else if (coef_fire) begin
                    acc_nxt  = acc >> LOGQ;
                    cnt_nxt  = cnt - CNT_Q;
                    sum_nxt  = sum + acc[LOGQ-1:0];
                    ccnt_nxt = ccnt + 10'd1;
                    if (ccnt == LAST_IDX) state_nxt = CHECK;
                end
            end
            CHECK: begin
                // Only the padding bits remain in acc here.
                acc_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = LAST;
            end
            LAST: begin
                if (coef_fire) state_nxt = DONE;
            end
            DONE: begin
                bcnt_nxt  = '0;
                ccnt_nxt  = '0;
                sum_nxt   = '0;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        in_ready_nxt   = (state_nxt == RUN) && (cnt_nxt < CNT_Q) && (bcnt_nxt < NBYTES);
        coef_valid_nxt = ((state_nxt == RUN) && (cnt_nxt >= CNT_Q)) || (state_nxt == LAST);
        coef_last_nxt  = (state_nxt == LAST);
        frame_done_nxt = (state_nxt == DONE);
        coef_data_nxt  = (state_nxt == LAST) ? neg_mod(sum_nxt) : acc_nxt[LOGQ-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            acc          <= '0;
            cnt          <= '0;
            bcnt         <= '0;
            ccnt         <= '0;
            sum          <= '0;
            in_ready_r   <= 1'b0;
            coef_valid_r <= 1'b0;
            coef_last_r  <= 1'b0;
            frame_done_r <= 1'b0;
            coef_data_r  <= '0;
        end else begin
            state        <= state_nxt;
            acc          <= acc_nxt;
            cnt          <= cnt_nxt;
            bcnt         <= bcnt_nxt;
            ccnt         <= ccnt_nxt;
            sum          <= sum_nxt;
            in_ready_r   <= in_ready_nxt;
            coef_valid_r <= coef_valid_nxt;
            coef_last_r  <= coef_last_nxt;
            frame_done_r <= frame_done_nxt;
            coef_data_r  <= coef_data_nxt;
        end
    end

`ifdef UNPACK_RQ0_PAD_CHECK_EN
    logic pad_flag;

    // Sticky until the first byte of the following frame is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pad_flag <= 1'b0;
        end else if (state == CHECK) begin
            if (acc[PAD_W-1:0] != '0) pad_flag <= 1'b1;
        end else if (byte_fire && (bcnt == 11'd0)) begin
            pad_flag <= 1'b0;
        end
    end

    assign bus.pad_err = pad_flag;
`else
    assign bus.pad_err = 1'b0;
`endif

    assign bus.in_ready   = in_ready_r;
    assign bus.coef_valid = coef_valid_r;
    assign bus.coef_last  = coef_last_r;
    assign bus.frame_done = frame_done_r;
    assign bus.coef_data  = coef_data_r;

endmodule

// File: tb/tb_unpack_rq0.sv
// tb_unpack_rq0
//   Self-checking bench for unpack_rq0: reset values, accept-to-output
//   latency, table of whole-frame patterns with hand-computed key
//   coefficients, a random frame with input gaps and a downstream stall,
//   and a reset in the middle of a frame followed by a clean frame.
module tb_unpack_rq0;

    logic clk;
    logic rst_n;

    unpack_rq0_if bus();

    unpack_rq0 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef UNPACK_RQ0_PAD_CHECK_EN
    localparam logic PAD_EN = 1'b1;
`else
    localparam logic PAD_EN = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem  [0:1137];
    logic [12:0] expv [0:700];
    logic [12:0] got  [0:700];
    logic        pad_exp;

    typedef struct {
        logic [7:0]  first_b;
        logic [7:0]  fill_b;
        logic [7:0]  last_b;
        logic [12:0] c0;
        logic [12:0] c1;
        logic [12:0] c700;
        logic        pad;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   32'(bus.in_ready),   0);
        check({tag, "_coef_valid"}, 32'(bus.coef_valid), 0);
        check({tag, "_coef_last"},  32'(bus.coef_last),  0);
        check({tag, "_frame_done"}, 32'(bus.frame_done), 0);
        check({tag, "_pad_err"},    32'(bus.pad_err),    0);
        check({tag, "_coef_data"},  32'(bus.coef_data),  0);
    endtask

    // Reference: pick each coefficient bit straight out of the byte stream.
    task automatic build_model();
        logic [12:0] v;
        logic [12:0] s;
        int          sb;
        s = '0;
        for (int i = 0; i < 700; i++) begin
            v = '0;
            for (int k = 0; k < 13; k++) begin
                sb   = 13 * i + k;
                v[k] = mem[sb / 8][7 - (sb % 8)];
            end
            expv[i] = v;
            s       = s + v;
        end
        expv[700] = 13'd0 - s;
        pad_exp   = PAD_EN && (mem[1137][3:0] != 4'd0);
    endtask

    // Streams mem[] in and collects 701 coefficients, then checks the frame.
    task automatic run_frame(input string tag, input bit gaps, input bit do_stall,
                             input bit check_time, input logic pad_want);
        int          bi, ci, cyc, stall_left, lasts, last_idx, stall_bad, fd, mism, first_bad;
        bit          stall_used;
        logic [12:0] held;
        bi = 0; ci = 0; cyc = 0; stall_left = 0; lasts = 0; last_idx = -1;
        stall_bad = 0; stall_used = 0; held = '0;
        while (ci < 701 && cyc < 8000) begin
            if (do_stall && !stall_used && ci == 350 && bus.coef_valid) begin
                stall_left = 10;
                stall_used = 1;
                held       = bus.coef_data;
            end
            if (stall_left > 0) begin
                bus.coef_ready = 1'b0;
                if (!bus.coef_valid || bus.coef_data !== held || bus.in_ready) stall_bad++;
                stall_left--;
            end else begin
                bus.coef_ready = 1'b1;
            end
            bus.in_valid = (bi < 1138) && (!gaps || $urandom_range(0, 2) != 0);
            bus.in_data  = (bi < 1138) ? mem[bi] : 8'h00;
            if (bus.coef_valid && bus.coef_ready) begin
                got[ci] = bus.coef_data;
                if (bus.coef_last) begin
                    lasts++;
                    last_idx = ci;
                end
                ci++;
            end
            if (bus.in_valid && bus.in_ready) bi++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid   = 1'b0;
        bus.coef_ready = 1'b1;
        check({tag, "_coef_count"}, ci, 701);
        check({tag, "_byte_count"}, bi, 1138);
        check({tag, "_last_count"}, lasts, 1);
        check({tag, "_last_index"}, last_idx, 700);
        if (check_time) check({tag, "_cycles"}, cyc, 1840);
        if (do_stall) begin
            check({tag, "_stall_seen"}, 32'(stall_used), 1);
            check({tag, "_stall_hold"}, stall_bad, 0);
        end
        // DONE cycle: frame_done pulses once, pad_err reflects the frame.
        check({tag, "_pad_err"}, 32'(bus.pad_err), 32'(pad_want));
        fd = 0;
        for (int c = 0; c < 3; c++) begin
            if (bus.frame_done) fd++;
            if (c == 2) check({tag, "_no_extra_coef"}, 32'(bus.coef_valid), 0);
            @(posedge clk); #1;
        end
        check({tag, "_frame_done_pulses"}, fd, 1);
        mism = 0; first_bad = -1;
        for (int i = 0; i < ci && i < 701; i++) begin
            if (got[i] !== expv[i]) begin
                mism++;
                if (first_bad < 0) first_bad = i;
            end
        end
        check({tag, "_stream_mismatches"}, mism, 0);
        if (first_bad >= 0)
            check($sformatf("%s_coef%0d", tag, first_bad), 32'(got[first_bad]), 32'(expv[first_bad]));
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bi, cyc, hold_bad;
        logic [12:0] h;

        vecs[0] = '{8'h00, 8'h00, 8'h00, 13'h0000, 13'h0000, 13'h0000, 1'b0};
        vecs[1] = '{8'h80, 8'h00, 8'h00, 13'h0001, 13'h0000, 13'h1FFF, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 8'hF0, 13'h1FFF, 13'h1FFF, 13'h02BC, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 8'hF1, 13'h1FFF, 13'h1FFF, 13'h02BC, PAD_EN};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 13'h0000, 13'h0000, 13'h0000, 1'b0};
        vecs[5] = '{8'h01, 8'h00, 8'h00, 13'h0080, 13'h0000, 13'h1F80, 1'b0};

        rst_n          = 1'b0;
        bus.in_data    = 8'h00;
        bus.in_valid   = 1'b0;
        bus.coef_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_release_in_ready", 32'(bus.in_ready), 1);

        // Two accepts then a coefficient on the following cycle.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h80;
        @(posedge clk); #1;
        check("lat_after1_coef_valid", 32'(bus.coef_valid), 0);
        check("lat_after1_in_ready",   32'(bus.in_ready),   1);
        bus.in_data = 8'h00;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("lat_after2_coef_valid", 32'(bus.coef_valid), 1);
        check("lat_after2_coef_data",  32'(bus.coef_data),  1);
        check("lat_after2_in_ready",   32'(bus.in_ready),   0);
        h = bus.coef_data;
        hold_bad = 0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (!bus.coef_valid || bus.coef_data !== h || bus.in_ready) hold_bad++;
        end
        bus.in_valid = 1'b0;
        check("lat_stall_hold", hold_bad, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("early_rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < 1138; j++) mem[j] = vecs[v].fill_b;
            mem[0]    = vecs[v].first_b;
            mem[1137] = vecs[v].last_b;
            build_model();
            run_frame($sformatf("vec%0d", v), 1'b0, 1'b0, 1'b1, vecs[v].pad);
            check($sformatf("vec%0d_c0", v),   32'(got[0]),   32'(vecs[v].c0));
            check($sformatf("vec%0d_c1", v),   32'(got[1]),   32'(vecs[v].c1));
            check($sformatf("vec%0d_c699", v), 32'(got[699]), 32'(vecs[v].c1));
            check($sformatf("vec%0d_c700", v), 32'(got[700]), 32'(vecs[v].c700));
        end

        for (int j = 0; j < 1138; j++) mem[j] = 8'($urandom);
        build_model();
        run_frame("rand_stall", 1'b1, 1'b1, 1'b0, pad_exp);

        for (int j = 0; j < 1138; j++) mem[j] = 8'($urandom);
        bi = 0; cyc = 0;
        bus.coef_ready = 1'b1;
        while (bi < 501 && cyc < 3000) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mem[bi];
            if (bus.in_ready) bi++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("midrst_bytes_sent", bi, 501);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j < 1138; j++) mem[j] = 8'(j * 37 + 5);
        build_model();
        run_frame("after_rst", 1'b1, 1'b0, 1'b0, pad_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unpack_rq0.md
# unpack_rq0

Streaming unpacker for packed Rq0 polynomials, and the receive-side inverse of the Rq0 byte packer. It accepts the 1138-byte packed form of an NTRU-HRSS ciphertext polynomial one byte per handshake and reconstructs 700 13-bit coefficients. It then appends coefficient 700, computed as the negated sum of the others mod 8192, so the downstream multiplier receives all 701 coefficients as a valid/ready stream. It sits between the ciphertext byte interface and the decapsulation datapath.

## Interface
- N, 701, polynomial length; the block emits N coefficients, N-1 of them from bytes.
- LOGQ, 13, coefficient width; only N=701 and LOGQ=13 are supported.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_data  in  8  packed byte.
- in_valid  in  1  byte present.
- in_ready  out  1  byte accepted on a cycle with in_valid && in_ready.
- coef_data  out  13  coefficient value.
- coef_valid  out  1  coef_data valid.
- coef_ready  in  1  downstream accepts on a cycle with coef_valid && coef_ready.
- coef_last  out  1  high with coef_valid on coefficient 700.
- frame_done  out  1  one-cycle pulse after coefficient 700 transfers.
- pad_err  out  1  sticky per frame; the 4 pad bits of byte 1137 were nonzero.

## Operation
- Bit order:
  - Byte j (0..1137) carries stream bits 8j+1..8j+8 in the order in_data[7], in_data[6], …, in_data[0], MSB first.
  - Coefficient i (0..699) is stream bits 13i+1..13i+13, LSB first. Stream bit 13i+1+k is coefficient bit k.
  - Stream bits 9101..9104, which are in_data[3:0] of byte 1137, are padding and must be zero.
- Datapath:
  - 20-bit accumulator acc and 5-bit fill count cnt.
  - On byte accept: acc[cnt+m] = in_data[7-m] for m=0..7, and cnt += 8.
  - On coefficient transfer: acc shifts right by 13, and cnt -= 13.
  - coef_data = acc[12:0] in RUN.
- Counters and sum:
  - 11-bit byte counter bcnt, 10-bit coefficient counter ccnt.
  - 13-bit sum register: sum = (sum + coef_data) mod 8192 on each transfer of coefficients 0..699.
- in_ready = (state==RUN) && (cnt<13) && (bcnt<1138). Bytes and coefficients are never transferred in the same cycle.
- States:
  - RUN: coef_valid = (cnt>=13).
    - On transfer of coefficient 699, go to CHECK. At that point cnt is 4 and bcnt is 1138.
  - CHECK (one cycle): if acc[3:0] != 0, set pad_err. Clear acc and cnt, then go to LAST.
  - LAST:
    - coef_valid = 1, coef_last = 1, coef_data = (8192 - sum) mod 8192.
    - On transfer, go to DONE.
  - DONE (one cycle): frame_done = 1.
    - Clear bcnt, ccnt and sum, then return to RUN ready for the next frame.
    - pad_err clears on the first byte accepted of the next frame.
- Bytes presented during CHECK, LAST or DONE are not accepted (in_ready = 0).

## Timing
- Reset values: in_ready=0, coef_valid=0, coef_last=0, frame_done=0, pad_err=0, coef_data=0.
  - State returns to RUN with all counters, acc and sum at zero.
  - in_ready rises the cycle after rst_n deasserts.
- Reset mid-frame discards all partial data. The next accepted byte is byte 0.
- Accept-to-output latency: coef_valid rises the cycle after the accept that brings cnt to >=13. Example: accepts at cycles 0 and 1 give coef_valid at cycle 2.
- All outputs are driven from flops; there is no combinational path from coef_ready or in_valid to any output.
- While coef_valid && !coef_ready, coef_data, coef_last and coef_valid hold stable, and in_ready stays 0.
- Best-case frame time: 1138 byte cycles + 700 coefficient cycles + CHECK + LAST + DONE = 1841 cycles.

## Configuration
- UNPACK_RQ0_PAD_CHECK_EN:
  - Defined: CHECK compares acc[3:0] against zero and drives pad_err as described.
  - Undefined: the CHECK comparison is removed, pad_err is tied to 0, and the state sequence and timing are unchanged.

## Test plan
- All 1138 bytes 0x00 -> 701 coefficients of 0, coef_last only on the 701st, one frame_done, pad_err=0.
- Byte 0 = 0x80, rest 0x00 -> coefficient 0 = 1, coefficients 1..699 = 0, coefficient 700 = 0x1FFF.
- Bytes 0..1136 = 0xFF, byte 1137 = 0xF0 -> coefficients 0..699 = 0x1FFF, coefficient 700 = 700 (0x2BC), pad_err=0.
- Same as above but byte 1137 = 0xF1 -> identical coefficients.
  - pad_err=1 from CHECK with the macro defined; pad_err=0 without it.
  - pad_err clears after the first byte of the next all-zero frame.
- Random bytes with coef_ready low for 10 cycles mid-frame and random in_valid gaps -> coef_data held stable while stalled, in_ready=0 during the stall, and the output stream matches the reference model.
- rst_n low for one cycle after byte 500 -> all outputs at reset values. A full following frame decodes correctly with exactly 701 coefficients.
